// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-port load/store unit sitting between a core and a word-wide
//   memory with a combinational read port. It handles byte, half and word
//   loads with sign or zero extension. Sub-word stores are done as a
//   read-modify-write. Misaligned, illegal-size and out-of-range requests
//   complete with an error and never touch memory.
//
// Ports
//   clock, reset        : rising-edge clock, async active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_we              : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend sub-word loads when 1
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_error          : request was rejected
//   mem_address         : word-aligned byte address to memory (0 when idle)
//   mem_data_in         : word written to memory
//   mem_we              : memory write enable
//   mem_data_out        : combinational read word from memory
module load_store_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    input  logic [31:0] mem_data_out
);

    localparam logic [31:0] MEM_LIM = 32'(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    // Holds the store data at accept; replaced by the merged word after RD.
    logic [31:0] wword_q, wword_d;

    logic        req_err;
    logic        accept;
    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] extended;

    assign accept = (state_q == S_IDLE) && req_valid;

    // Request checking on the live request inputs.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (req_addr >= MEM_LIM) req_err = 1'b1;
    end

    // Lane position of the latched access; a half uses only addr[1].
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'b00: begin
                shamt     = {addr_q[1:0], 3'b000};
                lane_mask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                shamt     = {addr_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: begin
                shamt     = 5'd0;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign merged  = (mem_data_out & ~lane_mask) | ((wword_q << shamt) & lane_mask);
    assign shifted = mem_data_out >> shamt;

    always_comb begin
        extended = shifted;
        case (size_q)
            2'b00:   extended = uns_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   extended = uns_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: extended = mem_data_out;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            wword_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wword_q <= wword_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)                state_d = S_RESP;
                    else if (!req_we)           state_d = S_RD;
                    else if (req_size == 2'b10) state_d = S_WR;
                    else                        state_d = S_RD;
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wword_d = wword_q;
        if (accept) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr;
            err_d   = req_err;
            rdata_d = 32'h0;
            wword_d = req_wdata;
        end else if (state_q == S_RD) begin
            if (we_q) wword_d = merged;
            else      rdata_d = extended;
        end
    end

    // Outputs are decoded from state so reset clears them at once.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        resp_valid  = (state_q == S_RESP);
        resp_error  = (state_q == S_RESP) && err_q;
        resp_rdata  = (state_q == S_RESP) ? rdata_q : 32'h0;
        mem_we      = (state_q == S_WR);
        mem_address = ((state_q == S_RD) || (state_q == S_WR))
                      ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_data_in = (state_q == S_WR) ? wword_q : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_dat = 32'h0;

    int n_chk = 0;
    int n_err = 0;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // Memory model: combinational read, write on rising edge; preload port
    // lets the bench seed words without a second driver.
    assign mem_data_out = mem[mem_address[11:2]];
    always @(posedge clock) begin
        if (pl_en)       mem[pl_idx] <= pl_dat;
        else if (mem_we) mem[mem_address[11:2]] <= mem_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_idx = a[11:2]; pl_dat = d;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    // Issue one request and watch until the response. lat is the cycle index
    // after the accept edge in which resp_valid is seen (0 = timed out).
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int wec, output logic [31:0] wdo,
                        output logic [31:0] wao, output int rdc);
        lat = 0; rd = 32'hX; er = 1'bX; wec = 0; wdo = 32'h0; wao = 32'h0; rdc = 0;
        @(negedge clock);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (mem_we) begin
                wec++; wdo = mem_data_in; wao = mem_address;
            end
            if (!req_ready && !mem_we && !resp_valid) rdc++;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_error;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
        else begin
            @(negedge clock);
            chk("ready_after_resp", 32'(req_ready), 32'd1);
        end
    endtask

    int          lat, wec, rdc;
    logic [31:0] rd, wdo, wao;
    logic        er;

    task automatic load_case(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input int exp_lat,
                             input logic [31:0] exp_rd, input logic exp_er);
        xact(1'b0, sz, uns, a, 32'h0, lat, rd, er, wec, wdo, wao, rdc);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        chk({tag, "_nowrite"}, 32'(wec), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        #12;
        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Sub-word loads and extension
        poke(32'h10, 32'h8000_00F0);
        load_case("lb_10",  2'b00, 1'b0, 32'h10, 2, 32'hFFFF_FFF0, 1'b0);
        load_case("lbu_10", 2'b00, 1'b1, 32'h10, 2, 32'h0000_00F0, 1'b0);
        load_case("lh_12",  2'b01, 1'b0, 32'h12, 2, 32'hFFFF_8000, 1'b0);
        load_case("lhu_12", 2'b01, 1'b1, 32'h12, 2, 32'h0000_8000, 1'b0);
        load_case("lb_13",  2'b00, 1'b0, 32'h13, 2, 32'hFFFF_FF80, 1'b0);
        load_case("lw_10",  2'b10, 1'b0, 32'h10, 2, 32'h8000_00F0, 1'b0);

        // Error requests: one cycle to response, no memory write
        load_case("lh_11_misal", 2'b01, 1'b0, 32'h11, 1, 32'h0, 1'b1);
        load_case("lw_12_misal", 2'b10, 1'b0, 32'h12, 1, 32'h0, 1'b1);
        load_case("size11",      2'b11, 1'b0, 32'h10, 1, 32'h0, 1'b1);
        load_case("lw_4096_oor", 2'b10, 1'b0, 32'd4096, 1, 32'h0, 1'b1);
        xact(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234, lat, rd, er, wec, wdo, wao, rdc);
        chk("sh_misal_err", 32'(er), 32'd1);
        chk("sh_misal_nowrite", 32'(wec), 32'd0);

        // Byte store read-modify-write
        poke(32'h10, 32'h1122_3344);
        xact(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, lat, rd, er, wec, wdo, wao, rdc);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_we_pulses", 32'(wec), 32'd1);
        chk("sb_wdata", wdo, 32'h1122_AB44);
        chk("sb_waddr", wao, 32'h10);
        chk("sb_rdata0", rd, 32'h0);
        chk("sb_err", 32'(er), 32'd0);
        chk("sb_mem", mem[4], 32'h1122_AB44);

        // Half store upper lane
        xact(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_BEEF, lat, rd, er, wec, wdo, wao, rdc);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_wdata", wdo, 32'hBEEF_AB44);

        // Word store: write in cycle after accept, no RD state
        xact(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, rd, er, wec, wdo, wao, rdc);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_we_pulses", 32'(wec), 32'd1);
        chk("sw_wdata", wdo, 32'hDEAD_BEEF);
        chk("sw_waddr", wao, 32'h20);
        chk("sw_no_rd", 32'(rdc), 32'd0);
        chk("sw_rdata0", rd, 32'h0);
        load_case("lw_20", 2'b10, 1'b0, 32'h20, 2, 32'hDEAD_BEEF, 1'b0);

        // Reset during RD of a byte store
        poke(32'h30, 32'h5566_7788);
        @(negedge clock);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h0000_0000; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        chk("abort_rd_addr", mem_address, 32'h30);
        chk("abort_rd_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_error", 32'(resp_error), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_address", mem_address, 32'h0);
        chk("abort_mem_data_in", mem_data_in, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        wec = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (mem_we) wec++;
        end
        chk("abort_nowrite", 32'(wec), 32'd0);
        chk("abort_mem_kept", mem[12], 32'h5566_7788);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        load_case("lbu_31_after", 2'b00, 1'b1, 32'h31, 2, 32'h0000_0077, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 4096, SHALL set the byte size of the attached word memory; byte addresses >= MEM_BYTES are out of range.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL mean the core presents a memory request.
REQ-005 req_ready  output  1  SHALL mean the unit accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select the access type: 1 = store, 0 = load.
REQ-007 req_size  input  2  SHALL encode the access width: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 req_unsigned  input  1  SHALL select zero-extension for sub-word loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  SHALL carry the byte address.
REQ-010 req_wdata  input  32  SHALL carry the store data, right-aligned.
REQ-011 resp_valid  output  1  SHALL pulse for one cycle to signal completion.
REQ-012 resp_rdata  output  32  SHALL carry the extended load data, valid when resp_valid is 1.
REQ-013 resp_error  output  1  SHALL flag a misaligned, illegal-size or out-of-range request, valid when resp_valid is 1.
REQ-014 mem_address  output  32  SHALL carry the word-aligned byte address {addr[31:2],2'b00} to the memory.
REQ-015 mem_data_in  output  32  SHALL carry the word to be written to the memory.
REQ-016 mem_we  output  1  SHALL be the memory write enable.
REQ-017 mem_data_out  input  32  SHALL carry the combinational read word from the memory.

Function
REQ-018 The FSM SHALL use four states: IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 On a rising edge in IDLE with req_valid=1, the unit SHALL latch we, size, unsigned, addr and wdata.
REQ-020 The unit SHALL ignore req_valid in every state other than IDLE.
REQ-021 A request SHALL be an error if size=11, if size=01 and addr[0]=1, if size=10 and addr[1:0]!=0, or if addr >= MEM_BYTES.
REQ-022 An error request SHALL transition IDLE->RESP with resp_error=1 and resp_rdata=0, and mem_we SHALL never assert for it.
REQ-023 A load SHALL transition IDLE->RD->RESP; at the RD edge it SHALL capture mem_data_out (resp_valid two cycles after acceptance).
REQ-024 A word store SHALL transition IDLE->WR->RESP (resp_valid two cycles after acceptance).
REQ-025 A byte or half store SHALL transition IDLE->RD->WR->RESP as a read-modify-write (resp_valid three cycles after acceptance).
REQ-026 mem_we SHALL be 1 only in WR, for exactly one cycle per store.
REQ-027 mem_address SHALL be held stable through RD and WR, and SHALL be 0 in IDLE.
REQ-028 The merge SHALL replace only byte lane addr[1:0] (byte) or lanes addr[1]*2..+1 (half) of the read word, preserving all other lanes.
REQ-029 For a load, the selected lane SHALL be shifted to bit 0 and then sign- or zero-extended per the latched unsigned bit; a word load SHALL pass the word unchanged.
REQ-030 In RESP, resp_valid SHALL be 1 for one cycle, followed by an unconditional return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-031 resp_rdata SHALL be 0 for stores.

Reset
REQ-032 Reset SHALL force IDLE with req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_we=0, mem_address=0 and mem_data_in=0.
REQ-033 Reset asserted mid-operation SHALL abort the access; if it is asserted before the WR cycle, no memory write SHALL occur.

Verification
REQ-034 Bench SHALL cover: memory word @0x10=0x8000_00F0, lb addr 0x10 -> resp_rdata=0xFFFF_FFF0 two cycles after accept; lbu -> 0x0000_00F0.
REQ-035 Bench SHALL cover: lh addr 0x12 on the same word -> 0xFFFF_8000; lh addr 0x11 -> resp_error=1 after one cycle, with mem_we never high.
REQ-036 Bench SHALL cover: sb 0xAB to 0x11 with the word holding 0x1122_3344 -> single mem_we pulse writing 0x1122_AB44, resp_valid three cycles after accept.
REQ-037 Bench SHALL cover: sw 0xDEAD_BEEF to 0x20 -> mem_we in the cycle after accept with mem_data_in=0xDEAD_BEEF, and no RD state.
REQ-038 Bench SHALL cover: lw addr 4096 with MEM_BYTES=4096 -> resp_error=1 and resp_rdata=0.
REQ-039 Bench SHALL cover: reset asserted during RD of an sb -> outputs reach their REQ-032 values immediately, no write occurs, and req_ready=1 after release.
